// File: rtl/udp_rx_frame_unpacker.sv
// Reassembles UDP payload bytes into one LEN-byte frame, validates packet length,
// aborts stalled packets and emits a one-cycle frame_valid or len_err per packet.
module udp_rx_frame_unpacker #(
  parameter int LEN     = 113,
  parameter int TIMEOUT = 1024
) (
  input  logic                gmii_clk,
  input  logic                rst_n,
  input  logic                rec_en,
  input  logic [7:0]          rec_data,
  input  logic                rec_pkt_done,
  input  logic [15:0]         rec_byte_num,
  output logic [LEN*8-1:0]    frame_out,
  output logic                frame_valid,
  output logic                len_err,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         err_cnt
);

  localparam int              FW    = LEN * 8;
  localparam int              TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [6:0]      LEN_C = 7'(LEN);
  localparam logic [15:0]     LEN_W = 16'(LEN);
  localparam logic [TW-1:0]   TMAX  = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DROP    = 2'd2;
  localparam logic [1:0] S_CHECK   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [15:0]   byte_num_q, byte_num_d;
  logic          abort_q, abort_d;
  logic [FW-1:0] frame_out_q, frame_out_d;
  logic          frame_valid_q, frame_valid_d;
  logic          len_err_q, len_err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic          start_new;
  logic [15:0]   err_cnt_inc;

  assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    timer_d       = timer_q;
    sh_d          = sh_q;
    byte_num_d    = rec_pkt_done ? rec_byte_num : byte_num_q;
    abort_d       = abort_q;
    frame_out_d   = frame_out_q;
    frame_valid_d = 1'b0;
    len_err_d     = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    start_new     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rec_en) begin
          start_new = 1'b1;
        end else if (rec_pkt_done) begin
          // Zero-length packet: CHECK fails it because byte_cnt is 0, keeping
          // the same done-to-pulse latency as every other packet.
          byte_cnt_d = 7'd0;
          state_d    = S_CHECK;
        end
      end

      S_COLLECT: begin
        if (rec_en) begin
          timer_d = '0;
          if (byte_cnt_q < LEN_C) begin
            byte_cnt_d = byte_cnt_q + 7'd1;
            sh_d       = {sh_q[FW-9:0], rec_data};
            if (rec_pkt_done) begin
              state_d = S_CHECK;
            end
          end else begin
            state_d = S_DROP;
            abort_d = rec_pkt_done;
          end
        end else if (rec_pkt_done) begin
          state_d = S_CHECK;
        end else if (timer_q == TMAX) begin
          state_d = S_DROP;
          abort_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_DROP: begin
        // abort_q marks the single reporting cycle; a byte seen here opens the next packet.
        if (abort_q) begin
          len_err_d  = 1'b1;
          err_cnt_d  = err_cnt_inc;
          byte_cnt_d = 7'd0;
          timer_d    = '0;
          abort_d    = 1'b0;
          state_d    = S_IDLE;
          start_new  = rec_en;
        end else if (rec_pkt_done) begin
          abort_d = 1'b1;
        end else if (rec_en) begin
          timer_d = '0;
        end else if (timer_q == TMAX) begin
          abort_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_CHECK: begin
        if (byte_cnt_q == LEN_C && byte_num_q == LEN_W) begin
          frame_out_d   = sh_q;
          frame_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end else begin
          len_err_d = 1'b1;
          err_cnt_d = err_cnt_inc;
        end
        byte_cnt_d = 7'd0;
        timer_d    = '0;
        state_d    = S_IDLE;
        start_new  = rec_en;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_new) begin
      byte_cnt_d = 7'd1;
      sh_d       = {sh_q[FW-9:0], rec_data};
      timer_d    = '0;
      state_d    = rec_pkt_done ? S_CHECK : S_COLLECT;
    end
  end

  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= 7'd0;
      timer_q       <= '0;
      sh_q          <= '0;
      byte_num_q    <= 16'd0;
      abort_q       <= 1'b0;
      frame_out_q   <= '0;
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      frame_cnt_q   <= 16'd0;
      err_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      timer_q       <= timer_d;
      sh_q          <= sh_d;
      byte_num_q    <= byte_num_d;
      abort_q       <= abort_d;
      frame_out_q   <= frame_out_d;
      frame_valid_q <= frame_valid_d;
      len_err_q     <= len_err_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign frame_out   = frame_out_q;
  assign frame_valid = frame_valid_q;
  assign len_err     = len_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_udp_rx_frame_unpacker.sv
// Bench for udp_rx_frame_unpacker: table of packets plus hand-written corner sequences,
// with a scoreboard queue predicting each frame_valid/len_err pulse and its cycle.
module tb_udp_rx_frame_unpacker;

  localparam int LEN     = 113;
  localparam int TIMEOUT = 1024;
  localparam int FW      = LEN * 8;

  logic          gmii_clk;
  logic          rst_n;
  logic          rec_en;
  logic [7:0]    rec_data;
  logic          rec_pkt_done;
  logic [15:0]   rec_byte_num;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          len_err;
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;

  udp_rx_frame_unpacker #(.LEN(LEN), .TIMEOUT(TIMEOUT)) dut (
    .gmii_clk     (gmii_clk),
    .rst_n        (rst_n),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .len_err      (len_err),
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
  );

  typedef struct {
    bit            good;
    logic [FW-1:0] frame;
    int            due;
  } exp_t;

  typedef struct {
    logic [7:0]  start;
    int          n;
    logic [15:0] bnum;
    bit          done_last;
    bit          exp_good;
  } vec_t;

  exp_t          exp_q[$];
  vec_t          vecs[8];
  int            cyc = 0;
  int            check_cnt = 0;
  int            pass_cnt = 0;
  logic [FW-1:0] mdl_frame = '0;
  logic [15:0]   mdl_fcnt = 16'd0;
  logic [15:0]   mdl_ecnt = 16'd0;

  initial gmii_clk = 1'b0;
  always #4 gmii_clk = ~gmii_clk;

  always @(posedge gmii_clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    else
      pass_cnt++;
  endtask

  task automatic checkFrame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int idx;
    check_cnt++;
    if (act !== exp) begin
      idx = 0;
      for (int i = LEN - 1; i >= 0; i--)
        if (act[8*i +: 8] !== exp[8*i +: 8]) idx = LEN - 1 - i;
      for (int i = 0; i < LEN; i++)
        if (act[FW-1-8*i -: 8] !== exp[FW-1-8*i -: 8]) begin idx = i; break; end
      $display("[TB] FAIL %s: first differing byte %0d got 0x%0h expected 0x%0h at cycle %0d",
               name, idx, act[FW-1-8*idx -: 8], exp[FW-1-8*idx -: 8], cyc);
    end else begin
      pass_cnt++;
    end
  endtask

  // Scoreboard: every pulse must match the oldest prediction, in kind and in cycle.
  always @(negedge gmii_clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_valid || len_err) begin
        if (frame_valid && len_err)
          checkOutput("pulse_exclusive", {30'd0, frame_valid, len_err}, 32'd2);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {30'd0, frame_valid, len_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_cycle", cyc, e.due);
          checkOutput("pulse_kind_valid", {31'd0, frame_valid}, {31'd0, e.good});
          if (e.good) begin
            mdl_frame = e.frame;
            mdl_fcnt  = mdl_fcnt + 16'd1;
          end else if (mdl_ecnt != 16'hFFFF) begin
            mdl_ecnt = mdl_ecnt + 16'd1;
          end
          checkFrame("frame_out", frame_out, mdl_frame);
          checkOutput("frame_cnt", {16'd0, frame_cnt}, {16'd0, mdl_fcnt});
          checkOutput("err_cnt", {16'd0, err_cnt}, {16'd0, mdl_ecnt});
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        checkOutput("missing_pulse", {30'd0, frame_valid, len_err}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge gmii_clk);
      rec_en       = 1'b0;
      rec_pkt_done = 1'b0;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge gmii_clk);
    if (exp_q.size() > 0) begin
      checkOutput("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  // Drives n bytes start, start+1, ... and a done pulse, then predicts the outcome.
  task automatic applyStimulus(input logic [7:0] start, input int n, input logic [15:0] bnum,
                               input bit done_last, input bit exp_good);
    logic [FW-1:0] f;
    exp_t          e;
    f = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge gmii_clk);
      rec_en       = 1'b1;
      rec_data     = start + 8'(i);
      rec_pkt_done = done_last && (i == n - 1);
      rec_byte_num = bnum;
      if (i < LEN) f[FW-1-8*i -: 8] = rec_data;
    end
    if (!(done_last && n > 0)) begin
      @(negedge gmii_clk);
      rec_en       = 1'b0;
      rec_pkt_done = 1'b1;
      rec_byte_num = bnum;
    end
    e.good  = exp_good;
    e.frame = f;
    e.due   = cyc + 2;
    exp_q.push_back(e);
  endtask

  initial begin
    int c_last;
    exp_t e;

    vecs[0] = '{8'h00, 113, 16'd113, 1'b0, 1'b1};
    vecs[1] = '{8'h20, 100, 16'd100, 1'b0, 1'b0};
    vecs[2] = '{8'h40, 120, 16'd120, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 113, 16'd113, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 113, 16'd113, 1'b1, 1'b1};
    vecs[5] = '{8'h30, 113, 16'd112, 1'b0, 1'b0};
    vecs[6] = '{8'h00,   0, 16'd0,   1'b0, 1'b0};
    vecs[7] = '{8'h55, 113, 16'd369, 1'b0, 1'b0};

    rst_n        = 1'b0;
    rec_en       = 1'b0;
    rec_data     = 8'h00;
    rec_pkt_done = 1'b0;
    rec_byte_num = 16'd0;
    repeat (3) @(negedge gmii_clk);
    checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_len_err", {31'd0, len_err}, 32'd0);
    checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    checkFrame("rst_frame_out", frame_out, '0);
    rst_n = 1'b1;
    idle(2);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].start, vecs[v].n, vecs[v].bnum, vecs[v].done_last, vecs[v].exp_good);
      idle(3);
      waitDrain();
      if (v == 0) begin
        checkOutput("first_byte_msb", {24'd0, frame_out[903:896]}, 32'h00);
        checkOutput("last_byte_lsb", {24'd0, frame_out[7:0]}, 32'h70);
      end
    end

    // Back-to-back: second packet's first byte lands in the CHECK cycle of the first.
    applyStimulus(8'hA0, 113, 16'd113, 1'b0, 1'b1);
    applyStimulus(8'hC3, 113, 16'd113, 1'b0, 1'b1);
    idle(3);
    waitDrain();

    // Stall: 50 bytes then silence long enough for the idle timer to abort.
    for (int i = 0; i < 50; i++) begin
      @(negedge gmii_clk);
      rec_en   = 1'b1;
      rec_data = 8'(i);
    end
    c_last  = cyc;
    e.good  = 1'b0;
    e.frame = '0;
    e.due   = c_last + TIMEOUT + 2;
    exp_q.push_back(e);
    idle(TIMEOUT + 10);
    waitDrain();
    applyStimulus(8'h07, 113, 16'd113, 1'b0, 1'b1);
    idle(3);
    waitDrain();

    // Reset in the middle of a packet wipes everything.
    for (int i = 0; i < 60; i++) begin
      @(negedge gmii_clk);
      rec_en   = 1'b1;
      rec_data = 8'(i + 9);
    end
    @(negedge gmii_clk);
    rst_n     = 1'b0;
    rec_en    = 1'b0;
    mdl_frame = '0;
    mdl_fcnt  = 16'd0;
    mdl_ecnt  = 16'd0;
    @(negedge gmii_clk);
    checkOutput("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("midrst_err_cnt", {16'd0, err_cnt}, 32'd0);
    checkFrame("midrst_frame_out", frame_out, '0);
    rst_n = 1'b1;
    idle(2);
    applyStimulus(8'h61, 113, 16'd113, 1'b0, 1'b1);
    idle(3);
    waitDrain();
    checkOutput("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    checkOutput("post_rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    idle(5);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
